// File: rtl/bit_debounce_strobe.sv
// Synchronises and debounces one raw level; emits the clean level plus one-cycle
// change strobes (en/rise/fall) for an enable-gated downstream flop.
//
// state  | meaning
// STABLE | q_out matches sync_out, or a mismatch has not yet been seen
// COUNT  | sync_out differs from q_out; counting consecutive differing cycles
module bit_debounce_strobe #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 16,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic hold,
  output logic q_out,
  output logic en_out,
  output logic rise_out,
  output logic fall_out,
  output logic busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("bit_debounce_strobe: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > (1 << CNT_W) - 1) begin : g_bad_debounce
    $error("bit_debounce_strobe: DEBOUNCE must be 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   q_nxt, en_nxt, rise_nxt, fall_nxt;
  logic                   accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= STABLE;
      cnt      <= '0;
      q_out    <= RESET_VAL;
      en_out   <= 1'b0;
      rise_out <= 1'b0;
      fall_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      q_out    <= q_nxt;
      en_out   <= en_nxt;
      rise_out <= rise_nxt;
      fall_out <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q_out;
    en_nxt    = 1'b0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    accept    = 1'b0;

    if (hold) begin
      // Freeze discards any partial count so the full window restarts afterwards.
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_out != q_out) begin
            if (DEBOUNCE == 1) begin
              accept = 1'b1;
            end else begin
              state_nxt = COUNT;
              cnt_nxt   = CNT_W'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        COUNT: begin
          if (sync_out == q_out) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    if (accept) begin
      q_nxt     = sync_out;
      en_nxt    = 1'b1;
      rise_nxt  = sync_out;
      fall_nxt  = ~sync_out;
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_bit_debounce_strobe.sv
// Directed bench for bit_debounce_strobe: default instance plus a DEBOUNCE=1,
// SYNC_STAGES=3 instance, with hand-computed per-edge expectations.
module tb_bit_debounce_strobe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic raw_in = 1'b0, hold = 1'b0;
  logic q_out, en_out, rise_out, fall_out, busy;
  logic raw2 = 1'b0, hold2 = 1'b0;
  logic q2, en2, rise2, fall2, busy2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bit_debounce_strobe dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .hold(hold),
    .q_out(q_out), .en_out(en_out), .rise_out(rise_out),
    .fall_out(fall_out), .busy(busy)
  );

  bit_debounce_strobe #(.SYNC_STAGES(3), .DEBOUNCE(1)) dut_fast (
    .clk(clk), .rst(rst), .raw_in(raw2), .hold(hold2),
    .q_out(q2), .en_out(en2), .rise_out(rise2),
    .fall_out(fall2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] got, got2;
    #1;
    got  = {q_out, en_out, rise_out, fall_out, busy};
    got2 = {q2, en2, rise2, fall2, busy2};
    tests_run++;
    if (got !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_default: got %b expected 00000", got);
    end
    tests_run++;
    if (got2 !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_fast: got %b expected 00000", got2);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      got = {q_out, en_out, rise_out, fall_out, busy};
      tests_run++;
      if (got !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_release edge %0d: got %b expected 00000", e, got);
      end
    end
  endtask

  task automatic test_rise();
    logic [4:0] got, exp;
    raw_in = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      got = {q_out, en_out, rise_out, fall_out, busy};
      exp = {(e >= 18), (e == 18), (e == 18), 1'b0, (e >= 3 && e <= 17)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL rise edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] got, exp;
    raw_in = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) raw_in = 1'b1;
      got = {q_out, en_out, rise_out, fall_out, busy};
      exp = {1'b1, 1'b0, 1'b0, 1'b0, (e >= 3 && e <= 12)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] got, exp;
    int strobes = 0;
    raw_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 3)  raw_in = 1'b1;
      if (e == 6)  raw_in = 1'b0;
      if (e == 9)  raw_in = 1'b1;
      if (e == 12) raw_in = 1'b0;
      if (en_out) strobes++;
      got = {q_out, en_out, rise_out, fall_out};
      exp = {(e < 30), (e == 30), 1'b0, (e == 30)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL bounce edge %0d: got %b expected %b", e, got, exp);
      end
    end
    tests_run++;
    if (strobes != 1) begin
      tests_failed++;
      $display("FAIL bounce_strobe_count: got %0d expected 1", strobes);
    end
  endtask

  task automatic test_hold();
    logic [4:0] got, exp;
    hold = 1'b1;
    raw_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      got = {q_out, en_out, rise_out, fall_out, busy};
      tests_run++;
      if (got !== 5'b00000) begin
        tests_failed++;
        $display("FAIL hold_active edge %0d: got %b expected 00000", e, got);
      end
    end
    hold = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      got = {q_out, en_out, rise_out, fall_out, busy};
      exp = {(e >= 16), (e == 16), (e == 16), 1'b0, (e <= 15)};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL hold_release edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] got;
    raw_in = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    tests_run++;
    if (busy !== 1'b1 || q_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_precond: got busy=%b q=%b expected busy=1 q=1", busy, q_out);
    end
    #2 rst = 1'b0;
    #1;
    got = {q_out, en_out, rise_out, fall_out, busy};
    tests_run++;
    if (got !== 5'b00000) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %b expected 00000", got);
    end
    #2 rst = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      got = {q_out, en_out, rise_out, fall_out, busy};
      tests_run++;
      if (got !== 5'b00000) begin
        tests_failed++;
        $display("FAIL areset_release edge %0d: got %b expected 00000", e, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    raw2 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      got = {q2, en2, rise2, fall2, busy2};
      exp = {(e >= 4), (e == 4), (e == 4), 1'b0, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL fast_rise edge %0d: got %b expected %b", e, got, exp);
      end
    end
    raw2 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      got = {q2, en2, rise2, fall2, busy2};
      exp = {(e < 4), (e == 4), 1'b0, (e == 4), 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL fast_fall edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    raw_in = 1'b1;
    for (int e = 1; e <= 20; e++) tick();
    raw_in = 1'b0;
    for (int e = 1; e <= 20; e++) tick();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
